eu_dispatch_scheduler: RTL and testbench

- Sits between front-end dispatch and the per-execution-unit issue queues on the backend dispatch bus.
- Each handshake captures one group of up to NUM_DISPATCH instructions, each carrying an allocated EU index, into a holding buffer.
- Drains the buffer to the per-EU write ports, at most one entry per EU per cycle, in slot order.
- Gated by per-EU issue-queue credits.

---
 rtl/eu_dispatch_scheduler.sv | 132 +++++++++++++
 tb/tb_eu_dispatch_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_dispatch_scheduler.sv
// Holds one dispatch group and drains it to per-EU issue-queue write ports under credit control.
// Optional: `define EU_DISPATCH_BYPASS_EN to accept a new group on the edge the buffer empties.
module eu_dispatch_scheduler #(
  parameter int NUM_DISPATCH = 2,
  parameter int LOG2_NUM_EU  = 2,
  parameter int IQ_DEPTH     = 4,
  parameter int ENTRY_W      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_DISPATCH*ENTRY_W-1:0]      instr_dispatch_i,
  input  logic [NUM_DISPATCH-1:0]              instr_dispatch_valid_i,
  input  logic [NUM_DISPATCH*LOG2_NUM_EU-1:0]  dispatched_instr_alloc_euidx_i,
  output logic                                 instr_dispatch_ready_o,
  input  logic                                 flush_i,
  output logic [(2**LOG2_NUM_EU)*ENTRY_W-1:0]  eu_instr_o,
  output logic [(2**LOG2_NUM_EU)-1:0]          eu_instr_valid_o,
  input  logic [(2**LOG2_NUM_EU)-1:0]          eu_credit_return_i,
  output logic                                 busy_o,
  output logic                                 credit_err_o
);
  localparam int NUM_EU = 2**LOG2_NUM_EU;
  localparam int CW     = $clog2(IQ_DEPTH+1);
  localparam logic [CW-1:0] CRED_MAX = CW'(IQ_DEPTH);

  typedef enum logic {EMPTY, DRAIN} state_t;
  state_t state, state_nxt;

  logic [NUM_DISPATCH-1:0] slot_valid;
  logic [ENTRY_W-1:0]      slot_entry [NUM_DISPATCH];
  logic [LOG2_NUM_EU-1:0]  slot_eu    [NUM_DISPATCH];
  logic [CW-1:0]           credit     [NUM_EU];
  logic [NUM_EU-1:0]       credit_nz;
  logic [NUM_EU-1:0]       eu_issue;
  logic [NUM_DISPATCH-1:0] slot_issue;
  logic                    all_issue;
  logic                    accept;

  always_comb begin
    for (int unsigned e = 0; e < NUM_EU; e++)
      credit_nz[e] = (credit[e] != '0);
  end

  // A slot issues when it is the oldest pending slot for its EU and that EU has a credit.
  always_comb begin
    slot_issue = '0;
    for (int unsigned i = 0; i < NUM_DISPATCH; i++) begin
      slot_issue[i] = slot_valid[i] & credit_nz[slot_eu[i]];
      for (int unsigned j = 0; j < i; j++)
        if (slot_valid[j] && (slot_eu[j] == slot_eu[i]))
          slot_issue[i] = 1'b0;
    end
    all_issue = &(~slot_valid | slot_issue);
  end

  assign accept   = instr_dispatch_ready_o & (|instr_dispatch_valid_i) & ~flush_i;
  assign eu_issue = eu_instr_valid_o & {NUM_EU{~flush_i}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = DRAIN;
      DRAIN: begin
        if (flush_i)        state_nxt = EMPTY;
        else if (accept)    state_nxt = DRAIN;
        else if (all_issue) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    eu_instr_valid_o = '0;
    eu_instr_o       = '0;
    for (int unsigned e = 0; e < NUM_EU; e++)
      for (int unsigned i = 0; i < NUM_DISPATCH; i++)
        if (slot_issue[i] && (slot_eu[i] == LOG2_NUM_EU'(e))) begin
          eu_instr_valid_o[e]                 = 1'b1;
          eu_instr_o[e*ENTRY_W +: ENTRY_W]    = slot_entry[i];
        end
    busy_o = (state == DRAIN);
`ifdef EU_DISPATCH_BYPASS_EN
    instr_dispatch_ready_o = (state == EMPTY) || ((state == DRAIN) && all_issue && !flush_i);
`else
    instr_dispatch_ready_o = (state == EMPTY);
`endif
  end

  // Accept only happens once every old slot is gone (EMPTY, or all issuing under bypass).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      for (int unsigned i = 0; i < NUM_DISPATCH; i++) begin
        slot_entry[i] <= '0;
        slot_eu[i]    <= '0;
      end
    end else if (flush_i) begin
      slot_valid <= '0;
    end else if (accept) begin
      slot_valid <= instr_dispatch_valid_i;
      for (int unsigned i = 0; i < NUM_DISPATCH; i++) begin
        slot_entry[i] <= instr_dispatch_i[i*ENTRY_W +: ENTRY_W];
        slot_eu[i]    <= dispatched_instr_alloc_euidx_i[i*LOG2_NUM_EU +: LOG2_NUM_EU];
      end
    end else begin
      slot_valid <= slot_valid & ~slot_issue;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_err_o <= 1'b0;
      for (int unsigned e = 0; e < NUM_EU; e++)
        credit[e] <= CRED_MAX;
    end else begin
      for (int unsigned e = 0; e < NUM_EU; e++) begin
        if (eu_issue[e] && !eu_credit_return_i[e]) begin
          credit[e] <= credit[e] - CW'(1);
        end else if (eu_credit_return_i[e] && !eu_issue[e]) begin
          if (credit[e] == CRED_MAX) credit_err_o <= 1'b1;
          else                       credit[e]    <= credit[e] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_eu_dispatch_scheduler.sv
// Directed self-checking bench for eu_dispatch_scheduler (NUM_DISPATCH=2, NUM_EU=4, IQ_DEPTH=4).
module tb_eu_dispatch_scheduler;
  localparam int ND = 2;
  localparam int LE = 2;
  localparam int NE = 4;
  localparam int EW = 32;
`ifdef EU_DISPATCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [ND*EW-1:0] instr_dispatch_i;
  logic [ND-1:0]    instr_dispatch_valid_i;
  logic [ND*LE-1:0] dispatched_instr_alloc_euidx_i;
  logic             instr_dispatch_ready_o;
  logic             flush_i;
  logic [NE*EW-1:0] eu_instr_o;
  logic [NE-1:0]    eu_instr_valid_o;
  logic [NE-1:0]    eu_credit_return_i;
  logic             busy_o;
  logic             credit_err_o;
  int total = 0;
  int bad   = 0;

  eu_dispatch_scheduler #(.NUM_DISPATCH(ND), .LOG2_NUM_EU(LE), .IQ_DEPTH(4), .ENTRY_W(EW)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_dispatch_i(instr_dispatch_i),
    .instr_dispatch_valid_i(instr_dispatch_valid_i),
    .dispatched_instr_alloc_euidx_i(dispatched_instr_alloc_euidx_i),
    .instr_dispatch_ready_o(instr_dispatch_ready_o),
    .flush_i(flush_i),
    .eu_instr_o(eu_instr_o),
    .eu_instr_valid_o(eu_instr_valid_o),
    .eu_credit_return_i(eu_credit_return_i),
    .busy_o(busy_o),
    .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] eu_word(input int e);
    return eu_instr_o[e*EW +: EW];
  endfunction

  task automatic set_group(input logic [1:0] v, input logic [1:0] e0, input logic [31:0] d0,
                           input logic [1:0] e1, input logic [31:0] d1);
    instr_dispatch_valid_i         = v;
    dispatched_instr_alloc_euidx_i = {e1, e0};
    instr_dispatch_i               = {d1, d0};
  endtask

  task automatic clr_group();
    set_group(2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
  endtask

  task automatic present(input logic [1:0] v, input logic [1:0] e0, input logic [31:0] d0,
                         input logic [1:0] e1, input logic [31:0] d1);
    set_group(v, e0, d0, e1, d1);
    tick();
    clr_group();
  endtask

  task automatic returns(input logic [3:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      eu_credit_return_i = m;
      tick();
    end
    eu_credit_return_i = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush_i = 1'b0; eu_credit_return_i = '0; clr_group();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    total++; if (instr_dispatch_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", instr_dispatch_ready_o); end
    total++; if (eu_instr_valid_o !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b exp=0000", eu_instr_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", credit_err_o); end
    total++; if (eu_instr_o !== '0) begin bad++; $display("FAIL rst_instr got=%h exp=0", eu_instr_o); end
    for (int r = 0; r < 4; r++) begin
      present(2'b11, 2'd0, 32'h100 + r, 2'd1, 32'h110 + r);
      total++; if (eu_instr_valid_o !== 4'b0011) begin bad++; $display("FAIL init_cred01_valid r=%0d got=%b exp=0011", r, eu_instr_valid_o); end
      total++; if (eu_word(0) !== 32'h100 + r || eu_word(1) !== 32'h110 + r) begin bad++; $display("FAIL init_cred01_data r=%0d got=%h exp=%h/%h", r, eu_instr_o, 32'h100 + r, 32'h110 + r); end
      tick();
      present(2'b11, 2'd2, 32'h120 + r, 2'd3, 32'h130 + r);
      total++; if (eu_instr_valid_o !== 4'b1100) begin bad++; $display("FAIL init_cred23_valid r=%0d got=%b exp=1100", r, eu_instr_valid_o); end
      total++; if (eu_word(2) !== 32'h120 + r || eu_word(3) !== 32'h130 + r) begin bad++; $display("FAIL init_cred23_data r=%0d got=%h", r, eu_instr_o); end
      tick();
    end
    returns(4'b1111, 4);
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL init_cred_restore_err got=%b exp=0", credit_err_o); end
  endtask

  task automatic test_parallel();
    present(2'b11, 2'd1, 32'h0000_00A1, 2'd2, 32'h0000_00B2);
    total++; if (eu_instr_valid_o !== 4'b0110) begin bad++; $display("FAIL par_valid got=%b exp=0110", eu_instr_valid_o); end
    total++; if (eu_instr_o !== {32'h0, 32'hB2, 32'hA1, 32'h0}) begin bad++; $display("FAIL par_data got=%h exp=%h", eu_instr_o, {32'h0, 32'hB2, 32'hA1, 32'h0}); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL par_busy1 got=%b exp=1", busy_o); end
    total++; if (instr_dispatch_ready_o !== BYP) begin bad++; $display("FAIL par_ready1 got=%b exp=%b", instr_dispatch_ready_o, BYP); end
    tick();
    total++; if (busy_o !== 1'b0 || instr_dispatch_ready_o !== 1'b1) begin bad++; $display("FAIL par_done got busy=%b ready=%b exp busy=0 ready=1", busy_o, instr_dispatch_ready_o); end
    total++; if (eu_instr_valid_o !== 4'b0000 || eu_instr_o !== '0) begin bad++; $display("FAIL par_idle got=%b/%h exp=0000/0", eu_instr_valid_o, eu_instr_o); end
    returns(4'b0110, 1);
  endtask

  task automatic test_same_eu();
    present(2'b11, 2'd3, 32'h0000_0A03, 2'd3, 32'h0000_0B03);
    total++; if (eu_instr_valid_o !== 4'b1000 || eu_word(3) !== 32'hA03) begin bad++; $display("FAIL ser_first got=%b/%h exp=1000/a03", eu_instr_valid_o, eu_word(3)); end
    tick();
    total++; if (eu_instr_valid_o !== 4'b1000 || eu_word(3) !== 32'hB03) begin bad++; $display("FAIL ser_second got=%b/%h exp=1000/b03", eu_instr_valid_o, eu_word(3)); end
    total++; if (instr_dispatch_ready_o !== BYP) begin bad++; $display("FAIL ser_ready2 got=%b exp=%b", instr_dispatch_ready_o, BYP); end
`ifdef EU_DISPATCH_BYPASS_EN
    present(2'b01, 2'd0, 32'h0000_0C00, 2'd0, 32'h0);
    total++; if (eu_instr_valid_o !== 4'b0001 || eu_word(0) !== 32'hC00) begin bad++; $display("FAIL ser_bypass got=%b/%h exp=0001/c00", eu_instr_valid_o, eu_word(0)); end
    tick();
    returns(4'b0001, 1);
`else
    tick();
    total++; if (instr_dispatch_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL ser_ready3 got ready=%b busy=%b exp ready=1 busy=0", instr_dispatch_ready_o, busy_o); end
`endif
    returns(4'b1000, 2);
  endtask

  task automatic test_credit_stall();
    for (int k = 0; k < 4; k++) begin
      present(2'b01, 2'd0, 32'h400 + k, 2'd0, 32'h0);
      total++; if (eu_instr_valid_o !== 4'b0001 || eu_word(0) !== 32'h400 + k) begin bad++; $display("FAIL stall_issue k=%0d got=%b/%h", k, eu_instr_valid_o, eu_word(0)); end
      tick();
    end
    present(2'b01, 2'd0, 32'h404, 2'd0, 32'h0);
    total++; if (eu_instr_valid_o !== 4'b0000 || busy_o !== 1'b1) begin bad++; $display("FAIL stall_fifth got valid=%b busy=%b exp 0000/1", eu_instr_valid_o, busy_o); end
    total++; if (instr_dispatch_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", instr_dispatch_ready_o); end
    tick();
    eu_credit_return_i = 4'b0001;
    total++; if (eu_instr_valid_o !== 4'b0000) begin bad++; $display("FAIL stall_same_cycle got=%b exp=0000", eu_instr_valid_o); end
    tick();
    eu_credit_return_i = '0;
    total++; if (eu_instr_valid_o !== 4'b0001 || eu_word(0) !== 32'h404) begin bad++; $display("FAIL stall_release got=%b/%h exp=0001/404", eu_instr_valid_o, eu_word(0)); end
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_done busy got=%b exp=0", busy_o); end
    returns(4'b0001, 4);
  endtask

  task automatic test_credit_accounting();
    present(2'b11, 2'd2, 32'h500, 2'd2, 32'h501);
    tick();
    tick();
    present(2'b01, 2'd2, 32'h502, 2'd0, 32'h0);
    tick();
    present(2'b01, 2'd2, 32'h503, 2'd0, 32'h0);
    total++; if (eu_instr_valid_o !== 4'b0100 || eu_word(2) !== 32'h503) begin bad++; $display("FAIL acc_last_credit got=%b/%h exp=0100/503", eu_instr_valid_o, eu_word(2)); end
    eu_credit_return_i = 4'b0100;
    tick();
    eu_credit_return_i = '0;
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL acc_no_err got=%b exp=0", credit_err_o); end
    present(2'b01, 2'd2, 32'h504, 2'd0, 32'h0);
    total++; if (eu_instr_valid_o !== 4'b0100 || eu_word(2) !== 32'h504) begin bad++; $display("FAIL acc_kept_credit got=%b/%h exp=0100/504", eu_instr_valid_o, eu_word(2)); end
    tick();
    present(2'b01, 2'd2, 32'h505, 2'd0, 32'h0);
    total++; if (eu_instr_valid_o !== 4'b0000 || busy_o !== 1'b1) begin bad++; $display("FAIL acc_empty got valid=%b busy=%b exp 0000/1", eu_instr_valid_o, busy_o); end
    returns(4'b0100, 1);
    total++; if (eu_instr_valid_o !== 4'b0100 || eu_word(2) !== 32'h505) begin bad++; $display("FAIL acc_release got=%b/%h exp=0100/505", eu_instr_valid_o, eu_word(2)); end
    tick();
    returns(4'b0100, 4);
    eu_credit_return_i = 4'b0010;
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", credit_err_o); end
    tick();
    eu_credit_return_i = '0;
    total++; if (credit_err_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", credit_err_o); end
    repeat (3) tick();
    total++; if (credit_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", credit_err_o); end
    for (int k = 0; k < 5; k++) begin
      present(2'b01, 2'd1, 32'h600 + k, 2'd0, 32'h0);
      total++; if (eu_instr_valid_o !== ((k < 4) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL err_saturate k=%0d got=%b exp=%b", k, eu_instr_valid_o, (k < 4) ? 4'b0010 : 4'b0000); end
      if (k < 4) tick();
    end
    returns(4'b0010, 1);
    tick();
    returns(4'b0010, 4);
  endtask

  task automatic test_flush();
    present(2'b11, 2'd0, 32'h700, 2'd0, 32'h701);
    tick();
    tick();
    present(2'b11, 2'd0, 32'h702, 2'd0, 32'h703);
    tick();
    tick();
    present(2'b11, 2'd0, 32'h704, 2'd0, 32'h705);
    total++; if (eu_instr_valid_o !== 4'b0000 || busy_o !== 1'b1) begin bad++; $display("FAIL flush_pre got valid=%b busy=%b exp 0000/1", eu_instr_valid_o, busy_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    total++; if (busy_o !== 1'b0 || instr_dispatch_ready_o !== 1'b1) begin bad++; $display("FAIL flush_post got busy=%b ready=%b exp 0/1", busy_o, instr_dispatch_ready_o); end
    total++; if (eu_instr_valid_o !== 4'b0000) begin bad++; $display("FAIL flush_no_strobe got=%b exp=0000", eu_instr_valid_o); end
    set_group(2'b01, 2'd1, 32'h706, 2'd0, 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    clr_group();
    total++; if (busy_o !== 1'b0 || eu_instr_valid_o !== 4'b0000) begin bad++; $display("FAIL flush_blocks_accept got busy=%b valid=%b exp 0/0000", busy_o, eu_instr_valid_o); end
    present(2'b01, 2'd0, 32'h707, 2'd0, 32'h0);
    total++; if (eu_instr_valid_o !== 4'b0000 || busy_o !== 1'b1) begin bad++; $display("FAIL flush_credit_zero got valid=%b busy=%b exp 0000/1", eu_instr_valid_o, busy_o); end
    returns(4'b0001, 1);
    total++; if (eu_instr_valid_o !== 4'b0001 || eu_word(0) !== 32'h707) begin bad++; $display("FAIL flush_return got=%b/%h exp=0001/707", eu_instr_valid_o, eu_word(0)); end
    tick();
    total++; if (credit_err_o !== 1'b1) begin bad++; $display("FAIL flush_err_sticky got=%b exp=1", credit_err_o); end
  endtask

  task automatic test_reset_mid_drain();
    present(2'b01, 2'd0, 32'h800, 2'd0, 32'h0);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_pre busy got=%b exp=1", busy_o); end
    reset_n = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0 || instr_dispatch_ready_o !== 1'b1 || credit_err_o !== 1'b0) begin bad++; $display("FAIL mid_async got busy=%b ready=%b err=%b exp 0/1/0", busy_o, instr_dispatch_ready_o, credit_err_o); end
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (eu_instr_valid_o !== 4'b0000 || busy_o !== 1'b0) begin bad++; $display("FAIL mid_discard got valid=%b busy=%b exp 0000/0", eu_instr_valid_o, busy_o); end
    present(2'b01, 2'd0, 32'h801, 2'd0, 32'h0);
    total++; if (eu_instr_valid_o !== 4'b0001 || eu_word(0) !== 32'h801) begin bad++; $display("FAIL mid_credit_reset got=%b/%h exp=0001/801", eu_instr_valid_o, eu_word(0)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_same_eu();
    test_credit_stall();
    test_credit_accounting();
    test_flush();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
